// File: rtl/hyperram_ctrl.sv
// HyperRAM single-word controller: one 16-bit read or write per request,
// linear burst, fixed or device-doubled initial latency, read timeout.
module hyperram_ctrl #(
  parameter int unsigned LATENCY    = 6,
  parameter int unsigned RST_CYCLES = 200,
  parameter int unsigned RD_TIMEOUT = 64
) (
  input  logic        ck,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_error,
  output logic        hr_ck,
  output logic        hr_ncs,
  output logic        hr_nreset,
  output logic [7:0]  hr_dq_out,
  output logic        hr_dq_oe,
  input  logic [7:0]  hr_dq_in,
  output logic        hr_rwds_out,
  output logic        hr_rwds_oe,
  input  logic        hr_rwds_in
);

  typedef enum logic [3:0] {
    StInit, StIdle, StCsSetup, StCa, StLat, StWdata, StRdata, StCsHold, StRecover
  } state_e;

  localparam logic [15:0] RstLast       = 16'(RST_CYCLES - 1);
  localparam logic [15:0] LatSingleLast = 16'(2 * LATENCY - 1);
  localparam logic [15:0] LatDoubleLast = 16'(4 * LATENCY - 1);
  localparam logic [15:0] RdLast        = 16'(RD_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        dbl_q, dbl_d;
  logic        got_q, got_d;
  logic        rwds_q;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [47:0] ca;
  logic [7:0]  ca_byte;
  logic        rwds_edge;

  assign ca        = {~write_q, 1'b0, 1'b1, addr_q[31:3], 13'b0, addr_q[2:0]};
  assign rwds_edge = hr_rwds_in ^ rwds_q;

  // Select the command/address byte for the current CA cycle, MSB byte first
  always_comb begin
    ca_byte = 8'h00;
    unique case (cnt_q[2:0])
      3'd0:    ca_byte = ca[47:40];
      3'd1:    ca_byte = ca[39:32];
      3'd2:    ca_byte = ca[31:24];
      3'd3:    ca_byte = ca[23:16];
      3'd4:    ca_byte = ca[15:8];
      3'd5:    ca_byte = ca[7:0];
      default: ca_byte = 8'h00;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state_q <= StInit;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dbl_q   <= 1'b0;
      got_q   <= 1'b0;
      rwds_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dbl_q   <= dbl_d;
      got_q   <= got_d;
      rwds_q  <= hr_rwds_in;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state: each state owns cnt_q from zero; cnt_d defaults to increment
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dbl_d   = dbl_q;
    got_d   = got_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StInit: begin
        if (cnt_q == RstLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StIdle: begin
        cnt_d = '0;
        if (req_valid) begin
          state_d = StCsSetup;
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          dbl_d   = 1'b0;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      StCsSetup: begin
        state_d = StCa;
        cnt_d   = '0;
      end
      StCa: begin
        // Device signals extra latency on RWDS mid-way through CA
        if (cnt_q == 16'd2) dbl_d = hr_rwds_in;
        if (cnt_q == 16'd5) begin
          state_d = StLat;
          cnt_d   = '0;
        end
      end
      StLat: begin
        if (cnt_q == (dbl_q ? LatDoubleLast : LatSingleLast)) begin
          state_d = write_q ? StWdata : StRdata;
          cnt_d   = '0;
          got_d   = 1'b0;
        end
      end
      StWdata: begin
        if (cnt_q == 16'd1) begin
          state_d = StCsHold;
          cnt_d   = '0;
        end
      end
      StRdata: begin
        if (rwds_edge && got_q) begin
          rdata_d[7:0] = hr_dq_in;
          state_d      = StCsHold;
          cnt_d        = '0;
        end else if (cnt_q == RdLast) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StCsHold;
          cnt_d   = '0;
        end else if (rwds_edge) begin
          rdata_d[15:8] = hr_dq_in;
          got_d         = 1'b1;
        end
      end
      StCsHold: begin
        state_d = StRecover;
        cnt_d   = '0;
      end
      StRecover: begin
        if (cnt_q == 16'd1) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StInit;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from state; all phase lengths are even so hr_ck = ~cnt_q[0]
  always_comb begin
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    hr_ncs     = 1'b1;
    hr_ck      = 1'b0;
    hr_nreset  = 1'b1;
    hr_dq_out  = 8'h00;
    hr_dq_oe   = 1'b0;
    hr_rwds_oe = 1'b0;
    unique case (state_q)
      StInit:    hr_nreset = 1'b0;
      StIdle:    req_ready = 1'b1;
      StCsSetup: hr_ncs = 1'b0;
      StCa: begin
        hr_ncs    = 1'b0;
        hr_ck     = ~cnt_q[0];
        hr_dq_oe  = 1'b1;
        hr_dq_out = ca_byte;
      end
      StLat, StRdata: begin
        hr_ncs = 1'b0;
        hr_ck  = ~cnt_q[0];
      end
      StWdata: begin
        hr_ncs     = 1'b0;
        hr_ck      = ~cnt_q[0];
        hr_dq_oe   = 1'b1;
        hr_rwds_oe = 1'b1;
        hr_dq_out  = cnt_q[0] ? wdata_q[7:0] : wdata_q[15:8];
      end
      StCsHold: begin
        hr_ncs    = 1'b0;
        rsp_valid = 1'b1;
      end
      StRecover: hr_ncs = 1'b1;
      default:   hr_nreset = 1'b0;
    endcase
  end

  assign hr_rwds_out = 1'b0;
  assign rsp_rdata   = rdata_q;
  assign rsp_error   = err_q;

endmodule

// File: tb/tb_hyperram_ctrl.sv
// Bench for hyperram_ctrl: transaction-level output model, simple HyperRAM
// device responder, and literal checks on the directed scenarios.
module tb_hyperram_ctrl;

  localparam int unsigned LAT   = 6;
  localparam int unsigned RSTC  = 200;
  localparam int unsigned RDTO  = 64;

  logic        ck = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_error;
  logic        hr_ck;
  logic        hr_ncs;
  logic        hr_nreset;
  logic [7:0]  hr_dq_out;
  logic        hr_dq_oe;
  logic [7:0]  hr_dq_in = '0;
  logic        hr_rwds_out;
  logic        hr_rwds_oe;
  logic        hr_rwds_in = 1'b0;

  hyperram_ctrl #(.LATENCY(LAT), .RST_CYCLES(RSTC), .RD_TIMEOUT(RDTO)) dut (
    .ck(ck), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .hr_ck(hr_ck), .hr_ncs(hr_ncs), .hr_nreset(hr_nreset),
    .hr_dq_out(hr_dq_out), .hr_dq_oe(hr_dq_oe), .hr_dq_in(hr_dq_in),
    .hr_rwds_out(hr_rwds_out), .hr_rwds_oe(hr_rwds_oe), .hr_rwds_in(hr_rwds_in)
  );

  always #5 ck = ~ck;

  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Device behaviour for the next transaction
  bit       dev_dbl = 0;
  bit       dev_toggle = 0;
  int       dev_delay = 0;
  bit [7:0] dev_b0 = 8'h12;
  bit [7:0] dev_b1 = 8'h34;

  // Device responder: idx 0 is the chip-select setup cycle, 1..6 CA, then latency
  int didx = 0;
  always @(negedge ck) begin
    int d;
    if (reset || hr_ncs) begin
      didx = 0;
      hr_rwds_in <= 1'b0;
      hr_dq_in   <= 8'h00;
    end else begin
      d = 7 + (dev_dbl ? 4 : 2) * int'(LAT) + dev_delay;
      if (didx >= 1 && didx <= 6) hr_rwds_in <= dev_dbl;
      else if (dev_toggle && didx == d) begin
        hr_rwds_in <= 1'b1;
        hr_dq_in   <= dev_b0;
      end else if (dev_toggle && didx == d + 1) begin
        hr_rwds_in <= 1'b0;
        hr_dq_in   <= dev_b1;
      end else hr_rwds_in <= 1'b0;
      didx++;
    end
  end

  // Model: expected per-cycle bus picture of a whole transaction
  typedef struct packed {
    logic        ncs;
    logic        ckv;
    logic        oe;
    logic [7:0]  dq;
    logic        rwoe;
    logic        rv;
    logic        err;
    logic        chk_rd;
    logic [15:0] rd;
  } step_t;

  step_t mq[$];
  int    init_left = 0;

  function automatic step_t mk(logic ncs, logic ckv, logic oe, logic [7:0] dq, logic rwoe);
    step_t s;
    s      = '0;
    s.ncs  = ncs;
    s.ckv  = ckv;
    s.oe   = oe;
    s.dq   = dq;
    s.rwoe = rwoe;
    return s;
  endfunction

  function automatic void model_txn(logic w, logic [31:0] a, logic [15:0] d);
    logic [47:0] ca;
    step_t       s;
    int          lat;
    int          nrd;
    bit          ok;
    ca = (48'(!w) << 47) | (48'd1 << 45) | (48'(a >> 3) << 16) | 48'(a & 32'd7);
    lat = (dev_dbl ? 4 : 2) * int'(LAT);
    mq.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
    for (int i = 0; i < 6; i++) mq.push_back(mk(1'b0, i % 2 == 0, 1'b1, 8'(ca >> (40 - 8 * i)), 1'b0));
    for (int i = 0; i < lat; i++) mq.push_back(mk(1'b0, i % 2 == 0, 1'b0, 8'h00, 1'b0));
    ok = 1;
    if (w) begin
      mq.push_back(mk(1'b0, 1'b1, 1'b1, d[15:8], 1'b1));
      mq.push_back(mk(1'b0, 1'b0, 1'b1, d[7:0], 1'b1));
    end else begin
      ok  = dev_toggle && (dev_delay + 2 <= int'(RDTO));
      nrd = ok ? dev_delay + 2 : int'(RDTO);
      for (int i = 0; i < nrd; i++) mq.push_back(mk(1'b0, i % 2 == 0, 1'b0, 8'h00, 1'b0));
    end
    s        = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    s.rv     = 1'b1;
    s.err    = !w && !ok;
    s.chk_rd = !w;
    s.rd     = (!w && ok) ? {dev_b0, dev_b1} : 16'h0000;
    mq.push_back(s);
    mq.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0));
    mq.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0));
  endfunction

  function automatic logic [32:0] vec(logic ncs, logic ckv, logic nrst, logic rdy, logic oe,
                                      logic [7:0] dq, logic rwoe, logic rwout, logic rv,
                                      logic err, logic [15:0] rd);
    return {ncs, ckv, nrst, rdy, oe, dq, rwoe, rwout, rv, err, rd};
  endfunction

  // Compare process: checks every cycle against the model
  always @(negedge ck) begin
    step_t       s;
    logic [32:0] act;
    if (reset) begin
      mq.delete();
      init_left = int'(RSTC);
      chk("reset_outputs",
          vec(hr_ncs, hr_ck, hr_nreset, req_ready, hr_dq_oe, hr_dq_out, hr_rwds_oe,
              hr_rwds_out, rsp_valid, rsp_error, rsp_rdata),
          vec(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 16'h0000));
    end else if (init_left > 0) begin
      act = vec(hr_ncs, hr_ck, hr_nreset, req_ready, hr_dq_oe, hr_dq_oe ? hr_dq_out : 8'h00,
                hr_rwds_oe, 1'b0, rsp_valid, 1'b0, 16'h0000);
      chk("init_cycle", act, vec(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 16'h0000));
      init_left--;
    end else if (mq.size() > 0) begin
      s   = mq.pop_front();
      act = vec(hr_ncs, hr_ck, hr_nreset, req_ready, hr_dq_oe, hr_dq_oe ? hr_dq_out : 8'h00,
                hr_rwds_oe, hr_rwds_oe ? hr_rwds_out : 1'b0, rsp_valid,
                rsp_valid ? rsp_error : 1'b0, (rsp_valid && s.chk_rd) ? rsp_rdata : 16'h0000);
      chk("txn_cycle", act, vec(s.ncs, s.ckv, 1, 0, s.oe, s.oe ? s.dq : 8'h00, s.rwoe, 1'b0,
                                s.rv, s.rv ? s.err : 1'b0, s.chk_rd ? s.rd : 16'h0000));
    end else begin
      act = vec(hr_ncs, hr_ck, hr_nreset, req_ready, hr_dq_oe, hr_dq_oe ? hr_dq_out : 8'h00,
                hr_rwds_oe, 1'b0, rsp_valid, 1'b0, 16'h0000);
      chk("idle_cycle", act, vec(1, 0, 1, 1, 0, 8'h00, 0, 0, 0, 0, 16'h0000));
      if (req_valid) model_txn(req_write, req_addr, req_wdata);
    end
  end

  // Recorder feeding the literal checks
  logic [63:0] bytes_sh = '0;
  int          nooe = 0;
  int          rvs = 0;
  int          nlow = 0;
  int          run = 0;
  int          last_gap = 0;
  logic [15:0] last_rd = '0;
  logic        last_err = 1'b0;

  always @(negedge ck) begin
    if (reset) begin
      nlow = 0;
      run  = 0;
    end else begin
      if (!hr_nreset) nlow++;
      if (!hr_ncs && hr_dq_oe) bytes_sh = {bytes_sh[55:0], hr_dq_out};
      if (!hr_ncs && !hr_dq_oe) nooe++;
      if (rsp_valid) begin
        rvs++;
        last_rd  = rsp_rdata;
        last_err = rsp_error;
      end
      if (hr_ncs) run++;
      else begin
        if (run > 0) last_gap = run;
        run = 0;
      end
    end
  end

  task automatic clr_mon();
    bytes_sh = '0;
    nooe     = 0;
    rvs      = 0;
  endtask

  task automatic send(logic w, logic [31:0] a, logic [15:0] d, bit hold);
    bit got;
    @(posedge ck);
    #1;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge ck);
      got = req_ready;
    end
    chk("handshake_seen", 64'(got), 64'd1);
    @(posedge ck);
    #1;
    if (!hold) req_valid = 1'b0;
    // Post-handshake changes must not reach the bus
    req_write = ~w;
    req_addr  = ~a;
    req_wdata = ~d;
  endtask

  task automatic wait_rsp();
    bit got;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge ck);
      got = rsp_valid;
    end
    chk("rsp_seen", 64'(got), 64'd1);
    repeat (2) @(posedge ck);
    #1;
  endtask

  task automatic wait_ready();
    bit got;
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge ck);
      got = req_ready;
    end
    chk("ready_seen", 64'(got), 64'd1);
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(posedge ck);
    #1 reset = 1'b0;
    wait_ready();
    chk("init_nreset_low_cycles", 64'(nlow), 64'd200);

    // Write, single latency
    dev_dbl = 0; dev_toggle = 0; dev_delay = 0;
    clr_mon();
    send(1'b1, 32'h0000_0005, 16'hA55A, 0);
    wait_rsp();
    chk("wr_bus_bytes", bytes_sh, 64'h2000_0000_0005_A55A);
    chk("wr_cs_low_no_drive", 64'(nooe), 64'd14);
    chk("wr_rsp_pulses", 64'(rvs), 64'd1);
    chk("wr_rsp_error", 64'(last_err), 64'd0);

    // Read, double latency, device toggles RWDS after 3 data cycles
    dev_dbl = 1; dev_toggle = 1; dev_delay = 3;
    clr_mon();
    send(1'b0, 32'h0000_0008, 16'h0000, 0);
    wait_rsp();
    chk("rd_ca_bytes", bytes_sh, 64'h0000_A000_0001_0000);
    chk("rd_cs_low_no_drive", 64'(nooe), 64'd31);
    chk("rd_data", 64'(last_rd), 64'h1234);
    chk("rd_error", 64'(last_err), 64'd0);

    // Read timeout, single latency
    dev_dbl = 0; dev_toggle = 0; dev_delay = 0;
    clr_mon();
    send(1'b0, 32'h0000_0123, 16'h0000, 0);
    wait_rsp();
    chk("to_cs_low_no_drive", 64'(nooe), 64'd78);
    chk("to_data", 64'(last_rd), 64'h0000);
    chk("to_error", 64'(last_err), 64'd1);

    // Back-to-back writes with req_valid held high
    clr_mon();
    send(1'b1, 32'h1234_5678, 16'hBEEF, 1);
    wait_rsp();
    send(1'b1, 32'h0000_0003, 16'h0F0F, 0);
    wait_rsp();
    chk("b2b_ncs_high_gap", 64'(last_gap), 64'd3);
    chk("b2b_rsp_pulses", 64'(rvs), 64'd2);

    // Reset during write latency
    dev_dbl = 0; dev_toggle = 0;
    clr_mon();
    send(1'b1, 32'h0000_0040, 16'h1111, 0);
    repeat (10) @(posedge ck);
    #2;
    chk("pre_reset_in_latency", 64'({hr_ncs, hr_dq_oe}), 64'd0);
    reset = 1'b1;
    #1;
    chk("reset_async_ncs_oe", 64'({hr_ncs, hr_dq_oe, hr_nreset}), 64'b100);
    repeat (3) @(posedge ck);
    #1 reset = 1'b0;
    wait_ready();
    chk("reinit_nreset_low_cycles", 64'(nlow), 64'd200);
    chk("aborted_no_rsp", 64'(rvs), 64'd0);

    // A write after the re-init still works
    clr_mon();
    send(1'b1, 32'h0000_0005, 16'h5AA5, 0);
    wait_rsp();
    chk("post_reset_wr_bytes", bytes_sh, 64'h2000_0000_0005_5AA5);

    repeat (4) @(posedge ck);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
